// File: rtl/caxi4dma_int_ctrl_mch.sv
// Per-channel DMA event FIFO, status register and maskable interrupt.
// Optional overflow tracking enabled by defining CAXI4DMA_INT_OVF_EN.
module caxi4dma_int_ctrl_mch #(
  parameter int NUM_INT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  CLOCK,
  input  logic                  RESETN,
  input  logic                  ctrlSel,
  input  logic                  ctrlWe,
  input  logic [4:0]            ctrlAddr,
  input  logic [31:0]           ctrlWrData,
  output logic [31:0]           ctrlRdData,
  input  logic [NUM_INT-1:0]    evValid,
  input  logic [NUM_INT-1:0]    evOpDone,
  input  logic [NUM_INT-1:0]    evWrErr,
  input  logic [NUM_INT-1:0]    evRdErr,
  input  logic [NUM_INT-1:0]    evInvDscrptr,
  input  logic [5*NUM_INT-1:0]  evIntDscrptrNum,
  input  logic [NUM_INT-1:0]    evExtDscrptr,
  input  logic [NUM_INT-1:0]    evStrDscrptr,
  input  logic [32*NUM_INT-1:0] evExtAddr,
  output logic [NUM_INT-1:0]    fifoFull,
  output logic [NUM_INT-1:0]    intr,
  output logic [NUM_INT-1:0]    intOvf
);

  localparam int FIFO_AW = $clog2(FIFO_DEPTH);
  localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, BUSY} st_t;

  logic [NUM_INT-1:0][31:0] w_rd;

  for (genvar g = 0; g < NUM_INT; g++) begin : g_ch
    logic [41:0]        r_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] r_wp;
    logic [FIFO_AW-1:0] r_rp;
    logic [FIFO_AW:0]   r_cnt;
    st_t                r_st;
    st_t                w_nst;
    logic [3:0]         r_stat;
    logic [5:0]         r_dcode;
    logic [31:0]        r_addr;
    logic [3:0]         r_mask;
    logic               r_full;
    logic               r_intr;
    logic               w_ovf;
    logic               w_wr;
    logic [2:0]         w_off;
    logic               w_empty;
    logic               w_isfull;
    logic               w_pop;
    logic               w_push;
    logic [5:0]         w_dcode;
    logic [41:0]        w_entry;
    logic [41:0]        w_head;
    logic [31:0]        w_rdc;

    assign w_off    = ctrlAddr[2:0];
    assign w_wr     = ctrlSel & ctrlWe & (ctrlAddr[4:3] == 2'(g));
    assign w_empty  = (r_cnt == '0);
    assign w_isfull = (r_cnt == CNT_FULL);
    assign w_push   = evValid[g] & (~w_isfull | w_pop);
    assign w_head   = r_mem[r_rp];
    assign w_dcode  = evStrDscrptr[g] ? 6'd33 :
                      evExtDscrptr[g] ? 6'd32 :
                      {1'b0, evIntDscrptrNum[5*g +: 5]};
    assign w_entry  = {evExtAddr[32*g +: 32], w_dcode,
                       evInvDscrptr[g], evRdErr[g],
                       evWrErr[g], evOpDone[g]};

    // next state and head pop
    always_comb begin
      w_nst = r_st;
      w_pop = 1'b0;
      unique case (r_st)
        IDLE: if (!w_empty) begin
          w_nst = BUSY;
          w_pop = 1'b1;
        end
        BUSY: if ((r_stat & r_mask) == 4'd0) w_nst = IDLE;
        default: w_nst = IDLE;
      endcase
    end

    // state register
    always_ff @(posedge CLOCK or negedge RESETN) begin
      if (!RESETN) r_st <= IDLE;
      else         r_st <= w_nst;
    end

    // event storage, no reset needed
    always_ff @(posedge CLOCK) begin
      if (w_push) r_mem[r_wp] <= w_entry;
    end

    // fifo pointers, level and registered full
    always_ff @(posedge CLOCK or negedge RESETN) begin
      if (!RESETN) begin
        r_wp   <= '0;
        r_rp   <= '0;
        r_cnt  <= '0;
        r_full <= 1'b0;
      end else begin
        if (w_push) r_wp <= r_wp + 1'b1;
        if (w_pop)  r_rp <= r_rp + 1'b1;
        r_cnt  <= r_cnt + {{FIFO_AW{1'b0}}, w_push}
                        - {{FIFO_AW{1'b0}}, w_pop};
        r_full <= w_isfull;
      end
    end

    // status load beats a concurrent clear
    always_ff @(posedge CLOCK or negedge RESETN) begin
      if (!RESETN) begin
        r_stat  <= '0;
        r_dcode <= '0;
        r_addr  <= '0;
      end else if (w_pop) begin
        r_stat  <= w_head[3:0];
        r_dcode <= w_head[9:4];
        r_addr  <= w_head[41:10];
      end else if (w_wr && w_off == 3'd2) begin
        r_stat  <= r_stat & ~ctrlWrData[3:0];
      end
    end

    // mask register
    always_ff @(posedge CLOCK or negedge RESETN) begin
      if (!RESETN)                     r_mask <= '0;
      else if (w_wr && w_off == 3'd1) r_mask <= ctrlWrData[3:0];
    end

`ifdef CAXI4DMA_INT_OVF_EN
    logic r_ovf;
    // sticky overflow, set beats clear
    always_ff @(posedge CLOCK or negedge RESETN) begin
      if (!RESETN)
        r_ovf <= 1'b0;
      else if (evValid[g] && w_isfull && !w_pop)
        r_ovf <= 1'b1;
      else if (w_wr && w_off == 3'd4 && ctrlWrData[31])
        r_ovf <= 1'b0;
    end
    assign w_ovf = r_ovf;
`else
    assign w_ovf = 1'b0;
`endif

    // registered interrupt
    always_ff @(posedge CLOCK or negedge RESETN) begin
      if (!RESETN) r_intr <= 1'b0;
      else r_intr <= (|(r_stat & r_mask)) | (w_ovf & r_mask[3]);
    end

    // per-channel register read
    always_comb begin
      w_rdc = '0;
      unique case (w_off)
        3'd0: w_rdc = {22'd0, r_dcode, r_stat};
        3'd1: w_rdc = {28'd0, r_mask};
        3'd3: w_rdc = r_addr;
        3'd4: begin
          w_rdc[FIFO_AW:0] = r_cnt;
          w_rdc[31]        = w_ovf;
        end
        default: w_rdc = '0;
      endcase
    end

    assign w_rd[g]     = w_rdc;
    assign fifoFull[g] = r_full;
    assign intr[g]     = r_intr;
    assign intOvf[g]   = w_ovf;
  end

  // channel select for read data
  always_comb begin
    ctrlRdData = '0;
    for (int i = 0; i < NUM_INT; i++)
      if (ctrlAddr[4:3] == 2'(i)) ctrlRdData = w_rd[i];
  end

endmodule

// File: tb/tb_caxi4dma_int_ctrl_mch.sv
// Bench for caxi4dma_int_ctrl_mch: directed cases plus random traffic
// against a list-based event model. Honours CAXI4DMA_INT_OVF_EN.
module tb_caxi4dma_int_ctrl_mch;

  localparam int N = 4;
  localparam int D = 4;
`ifdef CAXI4DMA_INT_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic          CLOCK = 1'b0;
  logic          RESETN = 1'b0;
  logic          ctrlSel = 1'b0;
  logic          ctrlWe = 1'b0;
  logic [4:0]    ctrlAddr = '0;
  logic [31:0]   ctrlWrData = '0;
  logic [31:0]   ctrlRdData;
  logic [N-1:0]  evValid = '0;
  logic [N-1:0]  evOpDone = '0;
  logic [N-1:0]  evWrErr = '0;
  logic [N-1:0]  evRdErr = '0;
  logic [N-1:0]  evInvDscrptr = '0;
  logic [5*N-1:0] evIntDscrptrNum = '0;
  logic [N-1:0]  evExtDscrptr = '0;
  logic [N-1:0]  evStrDscrptr = '0;
  logic [32*N-1:0] evExtAddr = '0;
  logic [N-1:0]  fifoFull;
  logic [N-1:0]  intr;
  logic [N-1:0]  intOvf;

  caxi4dma_int_ctrl_mch #(.NUM_INT(N), .FIFO_DEPTH(D)) dut (
    .CLOCK(CLOCK), .RESETN(RESETN),
    .ctrlSel(ctrlSel), .ctrlWe(ctrlWe), .ctrlAddr(ctrlAddr),
    .ctrlWrData(ctrlWrData), .ctrlRdData(ctrlRdData),
    .evValid(evValid), .evOpDone(evOpDone), .evWrErr(evWrErr),
    .evRdErr(evRdErr), .evInvDscrptr(evInvDscrptr),
    .evIntDscrptrNum(evIntDscrptrNum), .evExtDscrptr(evExtDscrptr),
    .evStrDscrptr(evStrDscrptr), .evExtAddr(evExtAddr),
    .fifoFull(fifoFull), .intr(intr), .intOvf(intOvf)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct packed {
    logic [3:0]  st;
    logic [5:0]  dc;
    logic [31:0] ad;
  } ev_t;

  ev_t        mq [N][D];
  int         mcnt [N];
  ev_t        ms [N];
  bit         mbusy [N];
  logic [3:0] mmask [N];
  bit         movf [N];
  bit         mintr [N];
  bit         mfull [N];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < N; c++) begin
      mcnt[c] = 0; ms[c] = '0; mbusy[c] = 0; mmask[c] = '0;
      movf[c] = 0; mintr[c] = 0; mfull[c] = 0;
    end
  endfunction

  // one clock edge of the reference behaviour
  function automatic void model_step();
    int   lvl, off;
    bit   ld, en, wr, drop;
    bit   intr_n, full_n, busy_n;
    ev_t  head, nev;
    for (int c = 0; c < N; c++) begin
      lvl    = mcnt[c];
      ld     = !mbusy[c] && lvl > 0;
      en     = |(ms[c].st & mmask[c]);
      wr     = ctrlSel && ctrlWe && (int'(ctrlAddr[4:3]) == c);
      off    = int'(ctrlAddr[2:0]);
      intr_n = en | (OVF && movf[c] && mmask[c][3]);
      full_n = (lvl == D);
      busy_n = mbusy[c] ? en : ld;
      head   = mq[c][0];
      drop   = 0;
      if (ld) begin
        for (int k = 0; k < D-1; k++) mq[c][k] = mq[c][k+1];
        mcnt[c]--;
      end
      if (evValid[c]) begin
        nev.st = {evInvDscrptr[c], evRdErr[c], evWrErr[c], evOpDone[c]};
        nev.dc = evStrDscrptr[c] ? 6'd33 : evExtDscrptr[c] ? 6'd32 :
                 {1'b0, evIntDscrptrNum[5*c +: 5]};
        nev.ad = evExtAddr[32*c +: 32];
        if (mcnt[c] < D) begin
          mq[c][mcnt[c]] = nev;
          mcnt[c]++;
        end else drop = 1;
      end
      if (ld) ms[c] = head;
      else if (wr && off == 2) ms[c].st = ms[c].st & ~ctrlWrData[3:0];
      if (wr && off == 1) mmask[c] = ctrlWrData[3:0];
      if (OVF) begin
        if (drop) movf[c] = 1;
        else if (wr && off == 4 && ctrlWrData[31]) movf[c] = 0;
      end
      mintr[c] = intr_n;
      mfull[c] = full_n;
      mbusy[c] = busy_n;
    end
  endfunction

  function automatic logic [31:0] mread(logic [4:0] a);
    int c;
    logic [31:0] v;
    c = int'(a[4:3]);
    v = '0;
    case (a[2:0])
      3'd0: v = {22'd0, ms[c].dc, ms[c].st};
      3'd1: v = {28'd0, mmask[c]};
      3'd3: v = ms[c].ad;
      3'd4: begin
        v[2:0] = 3'(mcnt[c]);
        v[31]  = movf[c];
      end
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic chk_outs(string tag);
    for (int c = 0; c < N; c++) begin
      chk({tag, "_intr"}, 32'(intr[c]), 32'(mintr[c]));
      chk({tag, "_full"}, 32'(fifoFull[c]), 32'(mfull[c]));
      chk({tag, "_ovf"}, 32'(intOvf[c]), 32'(movf[c]));
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    model_step();
    #1;
    chk_outs("tick");
    evValid = '0;
    ctrlSel = 1'b0;
    ctrlWe  = 1'b0;
  endtask

  task automatic push(int c, logic [3:0] st, logic [4:0] num,
                      bit ext, bit str, logic [31:0] addr);
    evValid[c]      = 1'b1;
    evOpDone[c]     = st[0];
    evWrErr[c]      = st[1];
    evRdErr[c]      = st[2];
    evInvDscrptr[c] = st[3];
    evExtDscrptr[c] = ext;
    evStrDscrptr[c] = str;
    evIntDscrptrNum[5*c +: 5] = num;
    evExtAddr[32*c +: 32]     = addr;
  endtask

  task automatic wr(logic [4:0] a, logic [31:0] d);
    ctrlSel = 1'b1; ctrlWe = 1'b1; ctrlAddr = a; ctrlWrData = d;
  endtask

  task automatic rd(logic [4:0] a, output logic [31:0] v);
    ctrlSel = 1'b1; ctrlWe = 1'b0; ctrlAddr = a;
    #1;
    v = ctrlRdData;
    chk("rd", v, mread(a));
    ctrlSel = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLOCK);
    RESETN = 1'b0;
    #1;
    model_reset();
    chk_outs("rst");
    repeat (2) @(negedge CLOCK);
    RESETN = 1'b1;
  endtask

  initial begin
    logic [31:0] v;
    model_reset();
    #2;
    chk_outs("por");
    rd(5'h00, v);
    rd(5'h04, v);
    @(negedge CLOCK);
    @(negedge CLOCK);
    RESETN = 1'b1;

    // 1: single event, interrupt and clear
    wr(5'h01, 32'hF); tick();
    push(0, 4'h1, 5'd5, 0, 0, 32'h1234_0000); tick();
    tick();
    rd(5'h00, v); chk("t1_status", v, 32'h51);
    chk("t1_intr_lo", 32'(intr[0]), 0);
    tick();
    chk("t1_intr_hi", 32'(intr[0]), 1);
    wr(5'h02, 32'h1); tick();
    tick();
    chk("t1_intr_clr", 32'(intr[0]), 0);

    // 2: three events queued, advance by clears
    for (int k = 0; k < 3; k++) begin
      push(0, 4'h2, 5'(k + 1), 0, 0, 32'h100 + k); tick();
    end
    tick();
    rd(5'h04, v); chk("t2_level", v, 32'h2);
    rd(5'h00, v); chk("t2_first", v, 32'h12);
    for (int k = 0; k < 3; k++) begin
      wr(5'h02, 32'hF); tick(); tick(); tick();
      rd(5'h00, v); rd(5'h03, v);
    end

    // 3: masked events drain silently
    push(1, 4'h3, 5'd7, 0, 0, 32'hA); tick();
    push(1, 4'h4, 5'd9, 1, 0, 32'hB); tick();
    repeat (5) tick();
    chk("t3_intr", 32'(intr[1]), 0);
    rd(5'h08, v); chk("t3_status", v, 32'h204);
    rd(5'h0C, v); chk("t3_level", v, 32'h0);

    // 4: overflow with channel 0 held busy
    for (int k = 0; k < 7; k++) begin
      push(0, 4'h1, 5'(k), 0, 0, 32'h200 + k); tick();
    end
    tick();
    chk("t4_full", 32'(fifoFull[0]), 1);
    chk("t4_ovf", 32'(intOvf[0]), 32'(OVF));
    rd(5'h04, v); chk("t4_fstat", v, {OVF, 31'h4});
    wr(5'h04, 32'h8000_0000); tick();
    chk("t4_ovf_clr", 32'(intOvf[0]), 0);
    for (int k = 0; k < 5; k++) begin
      wr(5'h02, 32'hF); tick(); tick(); tick();
    end
    rd(5'h04, v); chk("t4_empty", v, 32'h0);

    // 5: stream descriptor on channel 2
    push(2, 4'h0, 5'd3, 0, 1, 32'hDEAD_0000); tick();
    tick();
    rd(5'h10, v); chk("t5_dcode", v, 32'h210);
    rd(5'h13, v); chk("t5_addr", v, 32'hDEAD_0000);
    tick();
    chk("t5_intr", 32'(intr), 32'h0);

    // 6: reset while busy with two queued
    wr(5'h19, 32'hF); tick();
    for (int k = 0; k < 3; k++) begin
      push(3, 4'h8, 5'(k), 0, 0, 32'h300 + k); tick();
    end
    tick();
    do_reset();
    repeat (4) tick();
    chk("t6_intr", 32'(intr), 32'h0);
    rd(5'h1C, v); chk("t6_level", v, 32'h0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(2) == 0)
          push(c, 4'($urandom), 5'($urandom), 1'($urandom),
               ($urandom_range(7) == 0), $urandom);
      if ($urandom_range(2) == 0)
        wr(5'($urandom), $urandom);
      tick();
      rd(5'($urandom), v);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
